// File: rtl/seq_correlator.sv
// seq_correlator: correlates a serial AXI-Stream bit stream against a fixed reference
// pattern and reports the mismatch count with match / inverted-match flags.
module seq_correlator #(
    parameter int unsigned          SEQ_LEN    = 11,
    parameter logic [SEQ_LEN-1:0]   TARGET_SEQ = 11'b11100010010,
    parameter int unsigned          MAX_ERR    = 0,
    parameter int unsigned          MODE       = 0,
    parameter int unsigned          DETECT_INV = 0,
    localparam int unsigned         ERR_W      = $clog2(SEQ_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [ERR_W-1:0] m_tdata,
    output logic [1:0]       m_tuser,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready
);

    localparam logic [ERR_W-1:0] LenW    = ERR_W'(SEQ_LEN);
    localparam logic [ERR_W-1:0] MaxErrW = ERR_W'(MAX_ERR);
    localparam logic [ERR_W-1:0] InvThrW = ERR_W'(SEQ_LEN - MAX_ERR);

    logic [SEQ_LEN-1:0] window_q, window_d, window_next;
    logic [ERR_W-1:0]   fill_q, fill_d, fill_next;
    logic               m_tvalid_q, m_tvalid_d;
    logic [ERR_W-1:0]   m_tdata_q, m_tdata_d;
    logic [1:0]         m_tuser_q, m_tuser_d;
    logic               m_tlast_q, m_tlast_d;
    logic               accept;
    logic               verdict;
    logic               full;
    logic [SEQ_LEN-1:0] diff;
    logic [ERR_W-1:0]   err;

    // Handshake: a pending verdict blocks input unless it drains this cycle.
    always_comb begin
        s_tready = ~m_tvalid_q | m_tready;
        accept   = s_tvalid & s_tready;
        verdict  = accept & ((MODE != 0) | s_tlast);
        m_tvalid = m_tvalid_q;
        m_tdata  = m_tdata_q;
        m_tuser  = m_tuser_q;
        m_tlast  = m_tlast_q;
    end

    // Shift window and saturating fill count; both clear after a frame's last bit.
    always_comb begin
        window_next = (window_q << 1) | {{(SEQ_LEN-1){1'b0}}, s_tdata};
        fill_next   = (fill_q == LenW) ? LenW : fill_q + 1'b1;
        full        = (fill_next == LenW);
        window_d    = window_q;
        fill_d      = fill_q;
        if (accept) begin
            if (s_tlast) begin
                window_d = '0;
                fill_d   = '0;
            end else begin
                window_d = window_next;
                fill_d   = fill_next;
            end
        end
    end

    // Mismatch popcount over the window including the bit being accepted.
    always_comb begin
        diff = window_next ^ TARGET_SEQ;
        err  = '0;
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            err = err + ERR_W'(diff[i]);
        end
    end

    // Output register: load on a verdict, hold under backpressure, clear when drained.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        if (verdict) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = s_tlast;
            if (full) begin
                m_tdata_d    = err;
                m_tuser_d[0] = (err <= MaxErrW);
                m_tuser_d[1] = (DETECT_INV != 0) && (err >= InvThrW);
            end else begin
                // Partial window never matches either polarity.
                m_tdata_d = LenW;
                m_tuser_d = 2'b00;
            end
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            window_q   <= '0;
            fill_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            window_q   <= window_d;
            fill_q     <= fill_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tuser_q  <= m_tuser_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

endmodule

// File: tb/tb_seq_correlator.sv
// Bench for seq_correlator: three parameterisations (frame/exact, frame/tolerant,
// sliding/tolerant/inverted) checked against a frame-history reference model.
module tb_seq_correlator;
    localparam int N    = 11;
    localparam int EW   = 4;
    localparam int NDUT = 3;
    localparam logic [N-1:0] TGT = 11'b11100010010;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    logic          s_tdata_a  [NDUT];
    logic          s_tvalid_a [NDUT];
    logic          s_tlast_a  [NDUT];
    logic          m_tready_a [NDUT];
    logic          s_tready_a [NDUT];
    logic [EW-1:0] m_tdata_a  [NDUT];
    logic [1:0]    m_tuser_a  [NDUT];
    logic          m_tlast_a  [NDUT];
    logic          m_tvalid_a [NDUT];

    int total = 0;
    int bad   = 0;

    int mode_k   [NDUT] = '{0, 0, 1};
    int maxerr_k [NDUT] = '{0, 1, 1};
    int inv_k    [NDUT] = '{0, 0, 1};

    // Reference model: bits of the current frame plus the expected output beat.
    bit            hist [NDUT][$];
    logic          ev   [NDUT];
    logic [EW-1:0] ed   [NDUT];
    logic [1:0]    eu   [NDUT];
    logic          el   [NDUT];
    bit            acc_a [NDUT];

    always #5 i_clk = ~i_clk;

    seq_correlator #(.SEQ_LEN(N), .TARGET_SEQ(TGT), .MAX_ERR(0), .MODE(0), .DETECT_INV(0)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_tdata(s_tdata_a[0]), .s_tvalid(s_tvalid_a[0]), .s_tlast(s_tlast_a[0]),
        .s_tready(s_tready_a[0]), .m_tdata(m_tdata_a[0]), .m_tuser(m_tuser_a[0]),
        .m_tlast(m_tlast_a[0]), .m_tvalid(m_tvalid_a[0]), .m_tready(m_tready_a[0])
    );

    seq_correlator #(.SEQ_LEN(N), .TARGET_SEQ(TGT), .MAX_ERR(1), .MODE(0), .DETECT_INV(0)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_tdata(s_tdata_a[1]), .s_tvalid(s_tvalid_a[1]), .s_tlast(s_tlast_a[1]),
        .s_tready(s_tready_a[1]), .m_tdata(m_tdata_a[1]), .m_tuser(m_tuser_a[1]),
        .m_tlast(m_tlast_a[1]), .m_tvalid(m_tvalid_a[1]), .m_tready(m_tready_a[1])
    );

    seq_correlator #(.SEQ_LEN(N), .TARGET_SEQ(TGT), .MAX_ERR(1), .MODE(1), .DETECT_INV(1)) u_dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_tdata(s_tdata_a[2]), .s_tvalid(s_tvalid_a[2]), .s_tlast(s_tlast_a[2]),
        .s_tready(s_tready_a[2]), .m_tdata(m_tdata_a[2]), .m_tuser(m_tuser_a[2]),
        .m_tlast(m_tlast_a[2]), .m_tvalid(m_tvalid_a[2]), .m_tready(m_tready_a[2])
    );

    // Verdict for the frame so far: {count, user}, compared over the last N bits.
    function automatic logic [5:0] calc(input int k);
        int n;
        int err;
        logic [1:0] u;
        n = hist[k].size();
        if (n < N) return {4'(N), 2'b00};
        err = 0;
        for (int j = 0; j < N; j++) begin
            if (hist[k][n - N + j] != TGT[N - 1 - j]) err++;
        end
        u[0] = (err <= maxerr_k[k]);
        u[1] = (inv_k[k] != 0) && (err >= N - maxerr_k[k]);
        return {err[3:0], u};
    endfunction

    function automatic logic [7:0] out_vec(input int k);
        return {m_tvalid_a[k], m_tdata_a[k], m_tuser_a[k], m_tlast_a[k]};
    endfunction

    function automatic logic [7:0] mdl_vec(input int k);
        return {ev[k], ed[k], eu[k], el[k]};
    endfunction

    function automatic logic exp_rdy(input int k);
        return !ev[k] || m_tready_a[k];
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NDUT; k++) begin
            hist[k].delete();
            ev[k] = 1'b0; ed[k] = '0; eu[k] = '0; el[k] = 1'b0;
        end
    endtask

    task automatic set_in(input int k, input logic d, input logic v, input logic l,
                          input logic r);
        s_tdata_a[k] = d; s_tvalid_a[k] = v; s_tlast_a[k] = l; m_tready_a[k] = r;
        #1;
    endtask

    // Advance the model by one cycle for every DUT, then cross the clock edge.
    task automatic tick();
        bit hs;
        bit prod;
        logic [5:0] vr;
        for (int k = 0; k < NDUT; k++) begin
            acc_a[k] = s_tvalid_a[k] && exp_rdy(k);
            hs       = ev[k] && m_tready_a[k];
            prod     = 1'b0;
            if (acc_a[k]) begin
                hist[k].push_back(s_tdata_a[k]);
                prod = (mode_k[k] == 1) || s_tlast_a[k];
                if (prod) begin
                    vr = calc(k);
                    ed[k] = vr[5:2]; eu[k] = vr[1:0]; el[k] = s_tlast_a[k]; ev[k] = 1'b1;
                end
                if (s_tlast_a[k]) hist[k].delete();
                else if (hist[k].size() > N) void'(hist[k].pop_front());
            end
            if (!prod && hs) ev[k] = 1'b0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge i_clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (out_vec(k) !== 8'h00 || s_tready_a[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset k=%0d got out=%h rdy=%b exp out=00 rdy=1",
                         k, out_vec(k), s_tready_a[k]);
            end
        end
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_frame_match();
        for (int i = 0; i < N; i++) begin
            set_in(0, TGT[N - 1 - i], 1'b1, i == N - 1, 1'b1);
            total++;
            if (s_tready_a[0] !== exp_rdy(0)) begin
                bad++; $display("FAIL match_rdy got=%b exp=%b", s_tready_a[0], exp_rdy(0));
            end
            tick();
            total++;
            if (out_vec(0) !== mdl_vec(0)) begin
                bad++; $display("FAIL match_out beat=%0d got=%h exp=%h", i, out_vec(0), mdl_vec(0));
            end
        end
        total++;
        if (out_vec(0) !== {1'b1, 4'd0, 2'b01, 1'b1}) begin
            bad++; $display("FAIL match_verdict got=%h exp=83", out_vec(0));
        end
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        total++;
        if (m_tvalid_a[0] !== 1'b0) begin
            bad++; $display("FAIL match_drain got valid=%b exp=0", m_tvalid_a[0]);
        end
    endtask

    task automatic test_long_frame();
        int         rk [3] = '{0, 0, 1};
        logic [14:0] rf [3];
        logic [3:0] rd [3] = '{4'd0, 4'd1, 4'd1};
        logic [1:0] ru [3] = '{2'b01, 2'b00, 2'b01};
        int k;
        rf[0] = {4'b0000, TGT};
        rf[1] = {4'b0000, TGT} ^ 15'h0020;
        rf[2] = rf[1];
        for (int t = 0; t < 3; t++) begin
            k = rk[t];
            for (int i = 0; i < 15; i++) begin
                set_in(k, rf[t][14 - i], 1'b1, i == 14, 1'b1);
                tick();
                total++;
                if (out_vec(k) !== mdl_vec(k)) begin
                    bad++;
                    $display("FAIL long_out run=%0d beat=%0d got=%h exp=%h",
                             t, i, out_vec(k), mdl_vec(k));
                end
            end
            total++;
            if (m_tvalid_a[k] !== 1'b1 || m_tdata_a[k] !== rd[t] || m_tuser_a[k] !== ru[t]) begin
                bad++;
                $display("FAIL long_verdict run=%0d got v=%b d=%0d u=%b exp v=1 d=%0d u=%b",
                         t, m_tvalid_a[k], m_tdata_a[k], m_tuser_a[k], rd[t], ru[t]);
            end
            set_in(k, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic test_frame_boundary();
        logic [15:0] seq;
        seq = {5'b10110, TGT};
        for (int i = 0; i < 16; i++) begin
            set_in(0, seq[15 - i], 1'b1, (i == 4) || (i == 15), 1'b1);
            tick();
            total++;
            if (out_vec(0) !== mdl_vec(0)) begin
                bad++; $display("FAIL bound_out beat=%0d got=%h exp=%h", i, out_vec(0), mdl_vec(0));
            end
            if (i == 4) begin
                total++;
                if (out_vec(0) !== {1'b1, 4'd11, 2'b00, 1'b1}) begin
                    bad++; $display("FAIL bound_short got=%h exp=d9", out_vec(0));
                end
            end
        end
        total++;
        if (out_vec(0) !== {1'b1, 4'd0, 2'b01, 1'b1}) begin
            bad++; $display("FAIL bound_full got=%h exp=83", out_vec(0));
        end
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_sliding_inv();
        logic [7:0] want;
        for (int i = 0; i < N; i++) begin
            set_in(2, ~TGT[N - 1 - i], 1'b1, i == N - 1, 1'b1);
            tick();
            want = (i == N - 1) ? {1'b1, 4'd11, 2'b10, 1'b1} : {1'b1, 4'd11, 2'b00, 1'b0};
            total++;
            if (out_vec(2) !== want || out_vec(2) !== mdl_vec(2)) begin
                bad++;
                $display("FAIL slide_inv beat=%0d got=%h exp=%h model=%h",
                         i, out_vec(2), want, mdl_vec(2));
            end
        end
        set_in(2, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] snap;
        for (int i = 0; i < N; i++) begin
            set_in(0, TGT[N - 1 - i], 1'b1, i == N - 1, i != N - 1);
            tick();
        end
        snap = out_vec(0);
        total++;
        if (snap !== {1'b1, 4'd0, 2'b01, 1'b1}) begin
            bad++; $display("FAIL bp_pending got=%h exp=83", snap);
        end
        for (int c = 0; c < 5; c++) begin
            set_in(0, 1'b1, 1'b1, 1'b0, 1'b0);
            total++;
            if (s_tready_a[0] !== 1'b0) begin
                bad++; $display("FAIL bp_stall_rdy cyc=%0d got=%b exp=0", c, s_tready_a[0]);
            end
            tick();
            total++;
            if (out_vec(0) !== snap || out_vec(0) !== mdl_vec(0)) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, out_vec(0), snap);
            end
        end
        set_in(0, 1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (s_tready_a[0] !== 1'b1) begin
            bad++; $display("FAIL bp_release_rdy got=%b exp=1", s_tready_a[0]);
        end
        tick();
        total++;
        if (m_tvalid_a[0] !== 1'b0 || out_vec(0) !== mdl_vec(0)) begin
            bad++; $display("FAIL bp_drained got=%h exp=%h", out_vec(0), mdl_vec(0));
        end
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_midframe();
        int nver;
        logic [1:0] last_user;
        set_in(2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            set_in(0, TGT[N - 1 - i], 1'b1, 1'b0, 1'b1);
            if (i == 5) set_in(2, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(2, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (m_tvalid_a[2] !== 1'b1) begin
            bad++; $display("FAIL rst_pre got valid=%b exp=1", m_tvalid_a[2]);
        end
        i_rst_n = 1'b0;
        reset_model();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (out_vec(k) !== 8'h00) begin
                bad++; $display("FAIL rst_async k=%0d got=%h exp=00", k, out_vec(k));
            end
        end
        set_in(2, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        nver = 0;
        last_user = 2'b11;
        for (int i = 0; i < N + 2; i++) begin
            if (i < N) set_in(0, TGT[N - 1 - i], 1'b1, i == N - 1, 1'b1);
            else       set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            if (m_tvalid_a[0] === 1'b1) begin
                nver++;
                last_user = m_tuser_a[0];
            end
            total++;
            if (out_vec(0) !== mdl_vec(0)) begin
                bad++; $display("FAIL rst_frame beat=%0d got=%h exp=%h", i, out_vec(0), mdl_vec(0));
            end
        end
        total++;
        if (nver != 1 || last_user !== 2'b01) begin
            bad++; $display("FAIL rst_one_verdict got n=%0d u=%b exp n=1 u=01", nver, last_user);
        end
    endtask

    task automatic test_random();
        int pos;
        logic d, v, l, r;
        for (int k = 0; k < NDUT; k++) begin
            pos = 0;
            for (int c = 0; c < 400; c++) begin
                v = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 7);
                d = TGT[N - 1 - pos] ^ ($urandom_range(0, 7) == 0);
                l = (pos == N - 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
                set_in(k, d, v, l, r);
                total++;
                if (s_tready_a[k] !== exp_rdy(k)) begin
                    bad++;
                    $display("FAIL rand_rdy k=%0d cyc=%0d got=%b exp=%b",
                             k, c, s_tready_a[k], exp_rdy(k));
                end
                tick();
                total++;
                if (out_vec(k) !== mdl_vec(k)) begin
                    bad++;
                    $display("FAIL rand_out k=%0d cyc=%0d got=%h exp=%h",
                             k, c, out_vec(k), mdl_vec(k));
                end
                if (acc_a[k]) pos = (l || pos == N - 1) ? 0 : pos + 1;
            end
            set_in(k, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            s_tdata_a[k] = 1'b0; s_tvalid_a[k] = 1'b0; s_tlast_a[k] = 1'b0; m_tready_a[k] = 1'b1;
        end
        test_reset();
        test_frame_match();
        test_long_frame();
        test_frame_boundary();
        test_sliding_inv();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
